// File: rtl/bus_arbiter_mux.sv
// Registered N_SRC-way bus multiplexer: direct select (mode 0) or round-robin arbitration with tenure (mode 1).
// Optional forced handover after MAX_TENURE cycles is enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter_mux #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned N_SRC      = 8,
  parameter int unsigned SEL_W      = $clog2(N_SRC),
  parameter int unsigned MAX_TENURE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   mode,
  input  logic [N_SRC-1:0]       req,
  output logic [WIDTH-1:0]       bus_out,
  output logic [N_SRC-1:0]       grant,
  output logic [SEL_W-1:0]       owner,
  output logic                   valid
);

  localparam int unsigned LAST = N_SRC - 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state, state_nx;
  logic [SEL_W-1:0]   ptr, ptr_nx, owner_nx, succ;
  logic [SEL_W:0]     cand;
  logic               valid_nx, sel_ok;
  logic [WIDTH-1:0]   bus_nx;
  logic [N_SRC-1:0]   grant_nx;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TEN_W = $clog2(MAX_TENURE + 1);
  logic [TEN_W-1:0] tenure, tenure_nx;
`endif

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    return (32'(i) == LAST) ? '0 : SEL_W'(32'(i) + 1);
  endfunction

  // First set request at or above start, wrapping; MSB flags a hit.
  function automatic logic [SEL_W:0] pick(input logic [N_SRC-1:0] r, input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] idx;
    logic [SEL_W:0]   res;
    idx = start;
    res = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (!res[SEL_W] && r[idx]) res = {1'b1, idx};
      idx = wrap_inc(idx);
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] src_at(input logic [N_SRC*WIDTH-1:0] d, input logic [SEL_W-1:0] i);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < N_SRC; k++)
      if (32'(i) == k) v = d[k*WIDTH +: WIDTH];
    return v;
  endfunction

  // Out-of-range select only exists when N_SRC is not a power of two.
  if ((1 << SEL_W) == N_SRC) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = 32'(sel) < N_SRC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      bus_out <= '0;
      grant   <= '0;
      owner   <= '0;
      valid   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tenure  <= '0;
`endif
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      bus_out <= bus_nx;
      grant   <= grant_nx;
      owner   <= owner_nx;
      valid   <= valid_nx;
`ifdef BUS_TIMEOUT_EN
      tenure  <= tenure_nx;
`endif
    end
  end

  // Next owner, pointer and state decision.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    owner_nx  = owner;
    valid_nx  = 1'b0;
    cand      = '0;
    succ      = wrap_inc(owner);
`ifdef BUS_TIMEOUT_EN
    tenure_nx = tenure;
`endif
    if (!mode) begin
      state_nx = IDLE;
      if (sel_ok) begin
        owner_nx = sel;
        valid_nx = 1'b1;
      end
    end else if (state == IDLE) begin
      cand = pick(req, ptr);
      if (cand[SEL_W]) begin
        owner_nx  = cand[SEL_W-1:0];
        valid_nx  = 1'b1;
        state_nx  = OWNED;
`ifdef BUS_TIMEOUT_EN
        tenure_nx = TEN_W'(1);
`endif
      end
    end else if (req[owner]) begin
      valid_nx = 1'b1;
`ifdef BUS_TIMEOUT_EN
      if (tenure == TEN_W'(MAX_TENURE) && |(req & ~grant)) begin
        cand      = pick(req & ~grant, succ);
        owner_nx  = cand[SEL_W-1:0];
        ptr_nx    = succ;
        tenure_nx = TEN_W'(1);
      end else if (tenure != TEN_W'(MAX_TENURE)) begin
        tenure_nx = tenure + TEN_W'(1);
      end
`endif
    end else begin
      ptr_nx = succ;
      cand   = pick(req, succ);
      if (cand[SEL_W]) begin
        owner_nx  = cand[SEL_W-1:0];
        valid_nx  = 1'b1;
`ifdef BUS_TIMEOUT_EN
        tenure_nx = TEN_W'(1);
`endif
      end else begin
        state_nx = IDLE;
      end
    end
  end

  // Bus data and one-hot grant follow the chosen owner.
  always_comb begin
    bus_nx   = '0;
    grant_nx = '0;
    if (valid_nx) begin
      bus_nx   = src_at(src_data, owner_nx);
      grant_nx = N_SRC'(1) << owner_nx;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboarded random/directed bench for bus_arbiter_mux (8-source main instance, 6-source select-only instance).
module tb_bus_arbiter_mux;

  localparam int N  = 8;
  localparam int N6 = 6;
  localparam int MT = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  src_data = '0;
  logic [2:0]   sel = '0, sel6 = '0;
  logic         mode = 1'b0, mode6 = 1'b0;
  logic [7:0]   req = '0;
  logic [5:0]   req6 = '0;
  logic [7:0]   bus_out, bus6;
  logic [7:0]   grant;
  logic [5:0]   grant6;
  logic [2:0]   owner, owner6;
  logic         valid, valid6;

  always #5 clk = ~clk;

  bus_arbiter_mux #(.WIDTH(8), .N_SRC(N), .MAX_TENURE(MT)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .sel(sel), .mode(mode), .req(req),
    .bus_out(bus_out), .grant(grant), .owner(owner), .valid(valid));

  bus_arbiter_mux #(.WIDTH(8), .N_SRC(N6), .MAX_TENURE(MT)) dut6 (
    .clk(clk), .rst(rst), .src_data(src_data[47:0]), .sel(sel6), .mode(mode6), .req(req6),
    .bus_out(bus6), .grant(grant6), .owner(owner6), .valid(valid6));

  typedef struct {
    logic [7:0] bus;  logic [7:0] gnt;  logic [2:0] own;  logic vld;
    logic [7:0] bus6; logic [5:0] gnt6; logic [2:0] own6; logic vld6;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: who owns the bus, round-robin start, tenure count.
  bit   m_owned;
  int   m_own, m_ptr, m_ten, m_last6;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [7:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic cycle(input bit md, input int s, input logic [7:0] r, input int s6 = 0, input bit do_rst = 1'b0);
    logic [7:0] src [N];
    exp_t e;
    int k;
    @(negedge clk);
    if (do_rst) begin
      #1 rst = 1'b1;
      #1;
      chk("rst_bus", 32'(bus_out), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_valid6", 32'(valid6), 0);
      #1 rst = 1'b0;
      m_owned = 0; m_ptr = 0; m_ten = 0; m_last6 = 0;
    end
    mode = md; sel = 3'(s); req = r; sel6 = 3'(s6);
    for (int i = 0; i < N; i++) begin
      src[i] = 8'($urandom);
      src_data[i*8 +: 8] = src[i];
    end
    e = '{default: '0};
    if (!md) begin
      m_owned = 0;
      e.vld = 1'b1; e.own = 3'(s); e.gnt = 8'(1) << s; e.bus = src[s];
    end else begin
      if (!m_owned) begin
        k = search(r, m_ptr);
        if (k >= 0) begin m_owned = 1; m_own = k; m_ten = 1; end
      end else if (r[m_own]) begin
`ifdef BUS_TIMEOUT_EN
        if (m_ten == MT && (r & ~(8'(1) << m_own)) != 0) begin
          m_ptr = (m_own + 1) % N;
          m_own = search(r & ~(8'(1) << m_own), m_ptr);
          m_ten = 1;
        end else if (m_ten < MT) m_ten++;
`endif
      end else begin
        m_ptr = (m_own + 1) % N;
        k = search(r, m_ptr);
        if (k >= 0) begin m_own = k; m_ten = 1; end
        else m_owned = 0;
      end
      e.vld = m_owned;
      if (m_owned) begin e.own = 3'(m_own); e.gnt = 8'(1) << m_own; e.bus = src[m_own]; end
    end
    if (s6 < N6) begin
      e.vld6 = 1'b1; e.own6 = 3'(s6); e.gnt6 = 6'(1) << s6; e.bus6 = src[s6]; m_last6 = s6;
    end else begin
      e.own6 = 3'(m_last6);
    end
    q.push_back(e);
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid", 32'(valid), 32'(e.vld));
        chk("bus_out", 32'(bus_out), 32'(e.bus));
        chk("grant", 32'(grant), 32'(e.gnt));
        if (e.vld) chk("owner", 32'(owner), 32'(e.own));
        chk("valid6", 32'(valid6), 32'(e.vld6));
        chk("bus6", 32'(bus6), 32'(e.bus6));
        chk("grant6", 32'(grant6), 32'(e.gnt6));
        chk("owner6", 32'(owner6), 32'(e.own6));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    bit md;
    repeat (2) @(negedge clk);
    // Direct select, including out-of-range select on the 6-source instance.
    cycle(0, 3, 8'h00, 7, 1'b1);
    cycle(0, 3, 8'h00, 6);
    cycle(0, 5, 8'h00, 2);
    cycle(0, 1, 8'h00, 7);
    // Back-to-back handover then idle, and pointer resume.
    repeat (3) cycle(1, 0, 8'h24);
    repeat (2) cycle(1, 0, 8'h20);
    cycle(1, 0, 8'h00);
    cycle(1, 0, 8'h41);
    cycle(1, 0, 8'h01);
    cycle(1, 0, 8'h00);
    // Full rotation with two-cycle tenures.
    cycle(1, 0, 8'hFF, 0, 1'b1);
    repeat (9) begin
      cycle(1, 0, 8'hFF);
      cycle(1, 0, 8'hFF & ~(8'(1) << m_own));
    end
    // Reset while source 4 owns the bus.
    repeat (3) cycle(1, 0, 8'h10);
    cycle(1, 0, 8'hFF, 0, 1'b1);
    cycle(1, 0, 8'hFF);
    // Mode switch abandons ownership; return via IDLE.
    repeat (2) cycle(1, 0, 8'h04, 0, 1'b1);
    cycle(0, 7, 8'h04, 7);
    cycle(1, 0, 8'h04);
    cycle(1, 0, 8'h04);
    // Long tenure with a competing requester.
    repeat (3) cycle(1, 0, 8'h02, 0, 1'b1);
    repeat (25) cycle(1, 0, 8'h42);
    // Random traffic: sticky requests, occasional mode flips.
    r = 8'($urandom); md = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7, 0) == 0) r[b] = ~r[b];
      if ($urandom_range(31, 0) == 0) md = ~md;
      cycle(md, int'($urandom_range(7, 0)), r, int'($urandom_range(7, 0)),
            $urandom_range(499, 0) == 0);
    end
    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised, registered successor to the CPU's 8-source combinational bus multiplexer. It drives the shared datapath bus from N_SRC sources of WIDTH bits each. It has two modes: direct select, which keeps the legacy behaviour plus one register stage, and round-robin arbitration with ownership tenure, for DMA or multi-master use. It sits between the register file, memory and the bus consumers.

## Interface
- WIDTH, 8, bits per source and bus width
- N_SRC, 8, number of sources (≥2)
- SEL_W, $clog2(N_SRC), select/owner index width (derived, do not override)
- MAX_TENURE, 16, cycles before forced handover (used only with BUS_TIMEOUT_EN)
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- src_data  input  N_SRC*WIDTH  packed sources; source i at [i*WIDTH +: WIDTH]
- sel  input  SEL_W  source index, mode 0 only
- mode  input  1  0 = direct select, 1 = round-robin arbitration
- req  input  N_SRC  per-source bus request, mode 1 only
- bus_out  output  WIDTH  registered bus value
- grant  output  N_SRC  one-hot current owner; all-zero when bus is idle
- owner  output  SEL_W  index of the current owner
- valid  output  1  bus_out carries a granted source

## Operation
- Reset: bus_out=0, grant=0, owner=0, valid=0, state=IDLE, rr pointer ptr=0, tenure=0.
- Mode 0, direct select, evaluated every cycle:
  - If sel<N_SRC: bus_out<=src[sel], grant<=1<<sel, owner<=sel, valid<=1.
  - If sel≥N_SRC: bus_out<=0, grant<=0, valid<=0, owner unchanged.
  - FSM is forced to IDLE; ptr is held.
- Mode 1, arbitration FSM with states IDLE and OWNED:
  - IDLE, no req: bus_out<=0, grant<=0, valid<=0.
  - IDLE, any req: pick the first set req at or above ptr, wrapping modulo N_SRC. That source becomes owner, with grant, valid=1 and bus_out<=its data; tenure<=1; go to OWNED.
  - OWNED, req[owner]=1: bus_out<=src[owner] every cycle, so data tracks the source with 1-cycle latency. Tenure increments and saturates at MAX_TENURE.
  - OWNED, req[owner]=0 (release): ptr<=owner+1 mod N_SRC.
    - Another req pending: in the same edge, grant the next requester searching from owner+1. There is no dead cycle and tenure<=1.
    - No req pending: go to IDLE with outputs zeroed.
  - Mid-tenure, req bits of non-owners never disturb the owner, unless BUS_TIMEOUT_EN is set.
- Mode switch 1→0 abandons ownership immediately; the next edge applies mode-0 rules. Switch 0→1 starts from IDLE using the held ptr.
- Reset asserted mid-tenure clears all state asynchronously. After deassert, the first grant searches from ptr=0.
- grant is always one-hot or zero. owner always equals the index of the set grant bit when valid=1.

## Timing
- All outputs are registered. Inputs sampled at edge k appear on outputs after edge k.
- Mode 0 latency: 1 cycle from sel/src_data to bus_out.
- Mode 1 latency:
  - IDLE req at edge k: grant and valid after edge k.
  - Owner release sampled at edge k: new grant after edge k, for back-to-back handover.
- No combinational path from inputs to outputs.

## Configuration
- BUS_TIMEOUT_EN defined:
  - In OWNED, when tenure==MAX_TENURE and any other req is set, the bus is forcibly handed to the next requester from owner+1. This happens even though req[owner]=1.
  - ptr<=owner+1 and tenure<=1. The preempted source re-competes normally.
  - If no other req is set, the owner keeps the bus and tenure stays saturated.
- BUS_TIMEOUT_EN undefined: no preemption. The tenure counter and MAX_TENURE logic are not synthesised, and ownership ends only on release or mode switch.

## Test plan
- Reset then mode=0, sel=3, src3=8'hA5 -> after 1 edge bus_out=8'hA5, grant=8'b0000_1000, owner=3, valid=1. With N_SRC=6, sel=7 -> bus_out=0, grant=0, valid=0.
- mode=1, req=8'b0010_0100 from IDLE with ptr=0 -> owner=2. Drop req[2] -> the next edge grants owner=5 with no idle cycle. Drop req[5] -> IDLE, valid=0, ptr=6.
- mode=1, all req held high, each owner releases after 2 cycles -> grants rotate 0,1,…,7,0 in order.
- mode=1, owner=4 holding, rst pulsed for half a cycle -> outputs 0 immediately. After release with req=8'hFF -> owner=0.
- BUS_TIMEOUT_EN, MAX_TENURE=4, req[1] held and req[6] raised -> owner=1 for exactly 4 cycles, then owner=6. Without the macro -> owner stays 1 indefinitely.
- mode toggled 1→0 while owner=2, sel=7 -> next edge owner=7, grant=8'b1000_0000. Back to mode 1 with req=8'h04 -> owner=2 via IDLE.
